// File: rtl/gf_inverse_iter.sv
// Iterative GF(2^8) inverse (y = x^254) by MSB-first square-and-multiply for the AES S-box.
// Define GF_INV_RADIX4_EN to consume two exponent bits per cycle (latency 4 instead of 8).
module gf_inverse_iter #(
    parameter logic [7:0] POLY        = 8'h1B,
    parameter logic [7:0] RESET_ODATA = 8'h00
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [7:0] idata,
    input  logic       ivalid,
    output logic       iready,
    output logic [7:0] odata,
    output logic       ovalid,
    input  logic       oready
);

    localparam int unsigned DW = 8;
    localparam int unsigned PW = 2 * DW - 1;
`ifdef GF_INV_RADIX4_EN
    localparam int unsigned CW = 2;
`else
    localparam int unsigned CW = 3;
`endif
    localparam logic [CW-1:0] CNT_LAST = CW'((8 / (1 << (3 - CW))) - 1);
    localparam logic [DW-1:0] EXP      = 8'hFE;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        CALC = 2'd1,
        DONE = 2'd2
    } state_t;

    state_t          state, state_nxt;
    logic [DW-1:0]   x_q, x_nxt;
    logic [DW-1:0]   r_q, r_nxt;
    logic [CW-1:0]   cnt_q, cnt_nxt;
    logic [DW-1:0]   odata_nxt;
    logic            ovalid_nxt;
    logic            iready_nxt;
    logic [DW-1:0]   r_step;

    // Carry-less 8x8 product, then fold bits 14..8 back using {1,POLY}.
    function automatic logic [DW-1:0] gf_mul(input logic [DW-1:0] a, input logic [DW-1:0] b);
        logic [PW-1:0] p;
        p = '0;
        for (int i = 0; i < int'(DW); i++) begin
            if (b[i]) p = p ^ (PW'(a) << i);
        end
        for (int i = int'(PW) - 1; i >= int'(DW); i--) begin
            if (p[i]) p = p ^ (PW'({1'b1, POLY}) << (i - int'(DW)));
        end
        return p[DW-1:0];
    endfunction

    function automatic logic [DW-1:0] step(input logic [DW-1:0] r, input logic e,
                                           input logic [DW-1:0] x);
        logic [DW-1:0] sq;
        sq = gf_mul(r, r);
        return e ? gf_mul(sq, x) : sq;
    endfunction

`ifdef GF_INV_RADIX4_EN
    logic [2:0] idx_hi, idx_lo;
    assign idx_hi = 3'd7 - {cnt_q, 1'b0};
    assign idx_lo = 3'd6 - {cnt_q, 1'b0};
    assign r_step = step(step(r_q, EXP[idx_hi], x_q), EXP[idx_lo], x_q);
`else
    logic [2:0] idx;
    assign idx    = 3'd7 - cnt_q;
    assign r_step = step(r_q, EXP[idx], x_q);
`endif

    // State and registered outputs.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state  <= IDLE;
            x_q    <= '0;
            r_q    <= 8'h01;
            cnt_q  <= '0;
            odata  <= RESET_ODATA;
            ovalid <= 1'b0;
            iready <= 1'b1;
        end else begin
            state  <= state_nxt;
            x_q    <= x_nxt;
            r_q    <= r_nxt;
            cnt_q  <= cnt_nxt;
            odata  <= odata_nxt;
            ovalid <= ovalid_nxt;
            iready <= iready_nxt;
        end
    end

    // Next-state and next-output logic.
    always_comb begin
        state_nxt  = state;
        x_nxt      = x_q;
        r_nxt      = r_q;
        cnt_nxt    = cnt_q;
        odata_nxt  = odata;
        ovalid_nxt = ovalid;
        case (state)
            IDLE: begin
                if (ivalid && iready) begin
                    x_nxt     = idata;
                    r_nxt     = 8'h01;
                    cnt_nxt   = '0;
                    state_nxt = CALC;
                end
            end
            CALC: begin
                r_nxt = r_step;
                if (cnt_q == CNT_LAST) begin
                    cnt_nxt    = '0;
                    odata_nxt  = r_step;
                    ovalid_nxt = 1'b1;
                    state_nxt  = DONE;
                end else begin
                    cnt_nxt = cnt_q + CW'(1);
                end
            end
            DONE: begin
                if (ovalid && oready) begin
                    ovalid_nxt = 1'b0;
                    state_nxt  = IDLE;
                end
            end
            default: state_nxt = IDLE;
        endcase
        iready_nxt = (state_nxt == IDLE);
    end

endmodule

// File: tb/tb_gf_inverse_iter.sv
// Directed self-checking bench for gf_inverse_iter: vectors, latency, backpressure, reset, exhaustive.
module tb_gf_inverse_iter;

`ifdef GF_INV_RADIX4_EN
    localparam int LAT = 4;
`else
    localparam int LAT = 8;
`endif

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] idata = 8'h00;
    logic       ivalid = 1'b0;
    logic       iready;
    logic [7:0] odata;
    logic       ovalid;
    logic       oready = 1'b0;

    int checks = 0;
    int failures = 0;

    gf_inverse_iter dut (
        .clk    (clk),
        .rst    (rst),
        .idata  (idata),
        .ivalid (ivalid),
        .iready (iready),
        .odata  (odata),
        .ovalid (ovalid),
        .oready (oready)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Present x until one acceptance edge has passed.
    task automatic send(input logic [7:0] x);
        for (int i = 0; i < 50 && !iready; i++) tick();
        ivalid = 1'b1;
        idata  = x;
        tick();
        ivalid = 1'b0;
    endtask

    task automatic wait_ovalid(output int cyc);
        cyc = 0;
        do begin
            tick();
            cyc++;
        end while (!ovalid && cyc < 100);
    endtask

    // Reference multiply via repeated xtime.
    function automatic logic [7:0] ref_mul(input logic [7:0] a_in, input logic [7:0] b_in);
        logic [7:0] a, b, p;
        a = a_in; b = b_in; p = 8'h00;
        for (int i = 0; i < 8; i++) begin
            if (b[0]) p = p ^ a;
            a = a[7] ? ((a << 1) ^ 8'h1B) : (a << 1);
            b = b >> 1;
        end
        return p;
    endfunction

    function automatic logic [7:0] affine(input logic [7:0] b);
        logic [7:0] r1, r2, r3, r4;
        r1 = {b[6:0], b[7]};
        r2 = {b[5:0], b[7:6]};
        r3 = {b[4:0], b[7:5]};
        r4 = {b[3:0], b[7:4]};
        return b ^ r1 ^ r2 ^ r3 ^ r4 ^ 8'h63;
    endfunction

    logic [7:0] vin  [5] = '{8'h02, 8'h53, 8'h3D, 8'h01, 8'h00};
    logic [7:0] vexp [5] = '{8'h8D, 8'hCA, 8'hBB, 8'h01, 8'h00};

    initial begin
        int cyc;
        logic stable;
        logic seen;
        logic got;
        logic [7:0] res;
        logic [7:0] inv3d;
        int received;

        // Reset
        tick(); tick();
        check("rst_iready", 32'(iready), 32'd1);
        check("rst_ovalid", 32'(ovalid), 32'd0);
        check("rst_odata", 32'(odata), 32'h00);
        rst = 1'b1;
        tick();
        check("idle_iready", 32'(iready), 32'd1);
        check("idle_ovalid", 32'(ovalid), 32'd0);

        // Known vectors with oready=1
        oready = 1'b1;
        for (int i = 0; i < 5; i++) begin
            send(vin[i]);
            check("vec_iready_busy", 32'(iready), 32'd0);
            wait_ovalid(cyc);
            check("vec_latency", 32'(cyc), 32'(LAT));
            check("vec_odata", 32'(odata), 32'(vexp[i]));
            tick();
            check("vec_ovalid_clr", 32'(ovalid), 32'd0);
            check("vec_iready_back", 32'(iready), 32'd1);
        end

        // Backpressure
        oready = 1'b0;
        send(8'h53);
        wait_ovalid(cyc);
        check("bp_latency", 32'(cyc), 32'(LAT));
        stable = 1'b1;
        repeat (20) begin
            tick();
            if (!(ovalid === 1'b1 && odata === 8'hCA && iready === 1'b0)) stable = 1'b0;
        end
        check("bp_stable", 32'(stable), 32'd1);
        oready = 1'b1;
        tick();
        check("bp_ovalid_clr", 32'(ovalid), 32'd0);
        check("bp_iready", 32'(iready), 32'd1);

        // Busy input ignored outside IDLE
        oready = 1'b0;
        send(8'h02);
        tick(); tick();
        ivalid = 1'b1;
        idata  = 8'hFF;
        wait_ovalid(cyc);
        check("busy_odata", 32'(odata), 32'h8D);
        check("busy_iready", 32'(iready), 32'd0);
        stable = 1'b1;
        repeat (3) begin
            tick();
            if (!(ovalid === 1'b1 && odata === 8'h8D)) stable = 1'b0;
        end
        check("busy_hold", 32'(stable), 32'd1);
        oready = 1'b1;
        tick();
        check("busy_hs_iready", 32'(iready), 32'd1);
        tick();
        ivalid = 1'b0;
        check("busy_ff_accept", 32'(iready), 32'd0);
        wait_ovalid(cyc);
        check("ff_latency", 32'(cyc), 32'(LAT));
        check("ff_odata", 32'(odata), 32'h1C);
        tick();

        // Reset mid-CALC
        send(8'h3D);
        repeat (LAT / 2) tick();
        rst = 1'b0;
        #1;
        check("midrst_iready", 32'(iready), 32'd1);
        check("midrst_ovalid", 32'(ovalid), 32'd0);
        check("midrst_odata", 32'(odata), 32'h00);
        tick(); tick();
        rst = 1'b1;
        seen = 1'b0;
        repeat (15) begin
            tick();
            if (ovalid) seen = 1'b1;
        end
        check("midrst_no_ovalid", 32'(seen), 32'd0);
        send(8'h02);
        wait_ovalid(cyc);
        check("post_rst_latency", 32'(cyc), 32'(LAT));
        check("post_rst_odata", 32'(odata), 32'h8D);
        tick();

        // Exhaustive with random stalls
        received = 0;
        inv3d = 8'h00;
        for (int x = 0; x < 256; x++) begin
            send(8'(x));
            got = 1'b0;
            res = 8'h00;
            for (int c = 0; c < 300 && !got; c++) begin
                if (ovalid && oready) begin
                    res = odata;
                    got = 1'b1;
                end
                tick();
                oready = 1'($urandom_range(0, 1));
            end
            if (got) received++;
            check("exh_ovalid_clr", 32'(ovalid), 32'd0);
            if (x == 0) check("exh_zero", 32'(res), 32'h00);
            else check("exh_inverse", 32'(ref_mul(8'(x), res)), 32'h01);
            if (x == 8'h3D) inv3d = res;
        end
        check("exh_count", 32'(received), 32'd256);
        check("sbox_3d", 32'(affine(inv3d)), 32'h27);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
